// File: rtl/cam_capture_ctrl.sv
// rtl/cam_capture_ctrl.sv - camera byte-stream capture into the 4 x 512 x 32 frame buffer
// Optional build macro CAM_CAPTURE_TESTPAT_EN: write {21'h0, address} instead of camera data.
module cam_capture_ctrl #(
  parameter int FRAME_WORDS = 2048,
  parameter int LINE_CNT_W  = 10
) (
  input  logic                  PCLKI,
  input  logic                  WBs_RST_i,
  input  logic                  VSYNCI,
  input  logic                  HREFI,
  input  logic [7:0]            CAM_DAT,
  input  logic                  cap_arm_i,
  output logic                  cap_wr_en_o,
  output logic [10:0]           cap_wr_addr_o,
  output logic [31:0]           cap_wr_dat_o,
  output logic [1:0]            cap_bank_o,
  output logic                  cap_busy_o,
  output logic                  cap_done_o,
  output logic                  cap_ovf_o,
  output logic                  cap_align_err_o,
  output logic [LINE_CNT_W-1:0] cap_line_cnt_o
);

  localparam int CNT_W = $clog2(FRAME_WORDS) + 1;
  localparam logic [CNT_W-1:0] WORD_LIM = CNT_W'(FRAME_WORDS);

  typedef enum logic [1:0] {IDLE, WAIT_VS, CAPTURE, DONE} state_t;
  state_t state, state_nx;

  logic             arm_s1, arm_s2, arm_q;
  logic             vs_q, hr_q;
  logic [CNT_W-1:0] word_cnt;
  logic [1:0]       phase;
  logic [23:0]      pack;
  logic [10:0]      word_addr;
  logic             arm_rise, vs_rise, vs_fall, hr_fall;
  logic             capturing, start, sample, line_end;

  assign arm_rise  = arm_s2 & ~arm_q;
  assign vs_rise   = VSYNCI & ~vs_q;
  assign vs_fall   = ~VSYNCI & vs_q;
  assign hr_fall   = ~HREFI & hr_q;
  // An arm drop blocks sampling on the same edge that aborts, so no late word slips out.
  assign capturing = (state == CAPTURE) && arm_s2;
  assign start     = (state == WAIT_VS) && arm_s2 && vs_rise;
  assign sample    = capturing && VSYNCI && HREFI;
  assign line_end  = capturing && hr_fall;
  assign word_addr = 11'(word_cnt);

  assign cap_busy_o = (state == WAIT_VS) || (state == CAPTURE);
  assign cap_done_o = (state == DONE);

  always_ff @(posedge PCLKI or posedge WBs_RST_i) begin
    if (WBs_RST_i) state <= IDLE;
    else           state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (arm_rise) state_nx = WAIT_VS;
      WAIT_VS: if (!arm_s2) state_nx = IDLE;
               else if (vs_rise) state_nx = CAPTURE;
      CAPTURE: if (!arm_s2) state_nx = IDLE;
               else if (vs_fall) state_nx = DONE;
      DONE:    if (!arm_s2) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge PCLKI or posedge WBs_RST_i) begin
    if (WBs_RST_i) begin
      arm_s1          <= 1'b0;
      arm_s2          <= 1'b0;
      arm_q           <= 1'b0;
      vs_q            <= 1'b0;
      hr_q            <= 1'b0;
      word_cnt        <= '0;
      phase           <= 2'd0;
      pack            <= 24'h0;
      cap_wr_en_o     <= 1'b0;
      cap_wr_addr_o   <= 11'h0;
      cap_wr_dat_o    <= 32'h0;
      cap_bank_o      <= 2'd0;
      cap_ovf_o       <= 1'b0;
      cap_align_err_o <= 1'b0;
      cap_line_cnt_o  <= '0;
    end else begin
      arm_s1      <= cap_arm_i;
      arm_s2      <= arm_s1;
      arm_q       <= arm_s2;
      vs_q        <= VSYNCI;
      hr_q        <= HREFI;
      cap_wr_en_o <= 1'b0;
      if (start) begin
        word_cnt        <= '0;
        phase           <= 2'd0;
        cap_line_cnt_o  <= '0;
        cap_ovf_o       <= 1'b0;
        cap_align_err_o <= 1'b0;
      end else begin
        if (sample) begin
          // pack keeps the three earlier bytes of the word, oldest in [23:16]
          pack  <= {pack[15:0], CAM_DAT};
          phase <= phase + 2'd1;
          if (phase == 2'd3) begin
            if (word_cnt < WORD_LIM) begin
              cap_wr_en_o   <= 1'b1;
              cap_wr_addr_o <= word_addr;
              cap_bank_o    <= word_addr[10:9];
`ifdef CAM_CAPTURE_TESTPAT_EN
              cap_wr_dat_o  <= {21'h0, word_addr};
`else
              cap_wr_dat_o  <= {pack, CAM_DAT};
`endif
              word_cnt      <= word_cnt + CNT_W'(1);
            end else begin
              cap_ovf_o <= 1'b1;
            end
          end
        end
        if (line_end) begin
          if (cap_line_cnt_o != '1) cap_line_cnt_o <= cap_line_cnt_o + LINE_CNT_W'(1);
          if (phase != 2'd0) begin
            phase           <= 2'd0;
            cap_align_err_o <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_cam_capture_ctrl.sv
// tb/tb_cam_capture_ctrl.sv - directed self-checking bench for cam_capture_ctrl
module tb_cam_capture_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        vsync = 1'b0;
  logic        href = 1'b0;
  logic [7:0]  cam_dat = 8'h0;
  logic        cap_arm = 1'b0;
  logic        wr_en;
  logic [10:0] wr_addr;
  logic [31:0] wr_dat;
  logic [1:0]  bank;
  logic        busy, done, ovf, align;
  logic [9:0]  line_cnt;

  int passed = 0;
  int total  = 0;
  logic [7:0]  byte_ctr;
  logic [10:0] q_addr[$];
  logic [31:0] q_dat[$];
  logic [1:0]  q_bank[$];

  cam_capture_ctrl dut (
    .PCLKI(clk), .WBs_RST_i(rst), .VSYNCI(vsync), .HREFI(href), .CAM_DAT(cam_dat),
    .cap_arm_i(cap_arm), .cap_wr_en_o(wr_en), .cap_wr_addr_o(wr_addr),
    .cap_wr_dat_o(wr_dat), .cap_bank_o(bank), .cap_busy_o(busy), .cap_done_o(done),
    .cap_ovf_o(ovf), .cap_align_err_o(align), .cap_line_cnt_o(line_cnt)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (wr_en) begin
      q_addr.push_back(wr_addr);
      q_dat.push_back(wr_dat);
      q_bank.push_back(bank);
    end
  end

  function automatic logic [31:0] exp_word(input logic [10:0] a, input logic [31:0] packed_w);
`ifdef CAM_CAPTURE_TESTPAT_EN
    return {21'h0, a};
`else
    return packed_w;
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic hold(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive(input logic vs, input logic hr, input logic [7:0] d);
    @(negedge clk);
    vsync = vs; href = hr; cam_dat = d;
  endtask

  task automatic send_line(input int n);
    for (int i = 0; i < n; i++) begin
      drive(1'b1, 1'b1, byte_ctr);
      byte_ctr = byte_ctr + 8'd1;
    end
    drive(1'b1, 1'b0, 8'h0);
  endtask

  task automatic frame_start();
    drive(1'b0, 1'b0, 8'h0);
    drive(1'b1, 1'b0, 8'h0);
    drive(1'b1, 1'b0, 8'h0);
  endtask

  task automatic frame_end();
    drive(1'b0, 1'b0, 8'h0);
    drive(1'b0, 1'b0, 8'h0);
  endtask

  task automatic arm();
    @(negedge clk); cap_arm = 1'b1; hold(4);
  endtask

  task automatic disarm();
    @(negedge clk); cap_arm = 1'b0; hold(4);
  endtask

  task automatic clear_q();
    q_addr.delete(); q_dat.delete(); q_bank.delete();
  endtask

  initial begin
    hold(3);
    check("rst_wr_en", 32'(wr_en), 32'h0);
    check("rst_addr", 32'(wr_addr), 32'h0);
    check("rst_dat", wr_dat, 32'h0);
    check("rst_status", {26'h0, bank, busy, done, ovf, align}, 32'h0);
    check("rst_line_cnt", 32'(line_cnt), 32'h0);
    @(negedge clk); rst = 1'b0;

    // basic frame: 2 lines x 8 bytes
    arm();
    check("armed_busy", 32'(busy), 32'h1);
    frame_start();
    byte_ctr = 8'h01;
    send_line(8);
    send_line(8);
    drive(1'b0, 1'b0, 8'h0);
    check("done_before_fall", 32'(done), 32'h0);
    @(negedge clk);
    check("done_after_fall", 32'(done), 32'h1);
    check("basic_writes", 32'(q_dat.size()), 32'd4);
    check("basic_addr0", 32'(q_addr[0]), 32'h0);
    check("basic_addr3", 32'(q_addr[3]), 32'h3);
    check("basic_dat0", q_dat[0], exp_word(11'd0, 32'h01020304));
    check("basic_dat1", q_dat[1], exp_word(11'd1, 32'h05060708));
    check("basic_dat2", q_dat[2], exp_word(11'd2, 32'h090A0B0C));
    check("basic_dat3", q_dat[3], exp_word(11'd3, 32'h0D0E0F10));
    check("basic_line_cnt", 32'(line_cnt), 32'd2);

    // arm while VSYNCI already high
    disarm();
    check("idle_busy_done", {30'h0, busy, done}, 32'h0);
    clear_q();
    drive(1'b1, 1'b0, 8'h0);
    drive(1'b1, 1'b0, 8'h0);
    arm();
    check("vs_high_busy", 32'(busy), 32'h1);
    byte_ctr = 8'h20;
    send_line(8);
    check("vs_high_no_writes", 32'(q_dat.size()), 32'd0);
    frame_end();
    frame_start();
    byte_ctr = 8'h30;
    send_line(4);
    drive(1'b0, 1'b0, 8'h0);
    @(negedge clk);
    check("late_writes", 32'(q_dat.size()), 32'd1);
    check("late_addr", 32'(q_addr[0]), 32'h0);
    check("late_dat", q_dat[0], exp_word(11'd0, 32'h30313233));
    check("late_line_cnt", 32'(line_cnt), 32'd1);
    check("late_done", 32'(done), 32'h1);

    // partial line of 6 bytes
    disarm();
    clear_q();
    arm();
    frame_start();
    byte_ctr = 8'h40;
    send_line(6);
    byte_ctr = 8'h50;
    send_line(4);
    frame_end();
    check("align_writes", 32'(q_dat.size()), 32'd2);
    check("align_dat0", q_dat[0], exp_word(11'd0, 32'h40414243));
    check("align_dat1", q_dat[1], exp_word(11'd1, 32'h50515253));
    check("align_addr1", 32'(q_addr[1]), 32'h1);
    check("align_flag", 32'(align), 32'h1);
    check("align_line_cnt", 32'(line_cnt), 32'd2);

    // abort mid-line
    disarm();
    clear_q();
    arm();
    frame_start();
    check("align_cleared", 32'(align), 32'h0);
    byte_ctr = 8'h70;
    send_line(4);
    drive(1'b1, 1'b1, 8'h74);
    @(negedge clk);
    cap_arm = 1'b0; cam_dat = 8'h75;
    for (int i = 0; i < 10; i++) drive(1'b1, 1'b1, 8'h76 + 8'(i));
    drive(1'b1, 1'b0, 8'h0);
    hold(2);
    check("abort_writes", 32'(q_dat.size()), 32'd1);
    check("abort_busy", 32'(busy), 32'h0);
    check("abort_line_hold", 32'(line_cnt), 32'd1);
    frame_end();
    arm();
    clear_q();
    frame_start();
    check("rearm_line_clr", 32'(line_cnt), 32'd0);
    byte_ctr = 8'h60;
    send_line(4);
    frame_end();
    check("rearm_writes", 32'(q_dat.size()), 32'd1);
    check("rearm_addr", 32'(q_addr[0]), 32'h0);
    check("rearm_dat", q_dat[0], exp_word(11'd0, 32'h60616263));

    // overflow: 2049 words
    disarm();
    clear_q();
    arm();
    frame_start();
    byte_ctr = 8'h00;
    for (int l = 0; l < 16; l++) send_line(512);
    check("ovf_before", 32'(ovf), 32'h0);
    send_line(4);
    frame_end();
    check("ovf_writes", 32'(q_dat.size()), 32'd2048);
    check("ovf_last_addr", 32'(q_addr[2047]), 32'h7FF);
    check("ovf_last_bank", 32'(q_bank[2047]), 32'h3);
    check("ovf_bank511", 32'(q_bank[511]), 32'h0);
    check("ovf_bank512", 32'(q_bank[512]), 32'h1);
    check("ovf_last_dat", q_dat[2047], exp_word(11'h7FF, 32'hFCFDFEFF));
    check("ovf_flag", 32'(ovf), 32'h1);
    check("ovf_line_cnt", 32'(line_cnt), 32'd17);
    check("ovf_done", 32'(done), 32'h1);

    // reset mid-word
    disarm();
    clear_q();
    arm();
    frame_start();
    byte_ctr = 8'h90;
    send_line(4);
    for (int i = 0; i < 4; i++) drive(1'b1, 1'b1, 8'hA0 + 8'(i));
    @(posedge clk); #1;
    check("pre_rst_wr_en", 32'(wr_en), 32'h1);
    check("pre_rst_addr", 32'(wr_addr), 32'h1);
    #1; rst = 1'b1; cap_arm = 1'b0;
    #1;
    check("mid_rst_wr_en", 32'(wr_en), 32'h0);
    check("mid_rst_addr", 32'(wr_addr), 32'h0);
    check("mid_rst_dat", wr_dat, 32'h0);
    check("mid_rst_status", {28'h0, busy, done, ovf, align}, 32'h0);
    check("mid_rst_line_cnt", 32'(line_cnt), 32'h0);
    hold(2);
    rst = 1'b0;
    clear_q();
    frame_end();
    frame_start();
    byte_ctr = 8'hB0;
    send_line(8);
    frame_end();
    check("post_rst_writes", 32'(q_dat.size()), 32'd0);
    check("post_rst_busy", 32'(busy), 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
